// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
// FunSel encodings match the team's 16-bit function-select registers.
package fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ0 = 2'b01,
    ST_REQ1 = 2'b10,
    ST_LOAD = 2'b11
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetches one 16-bit instruction as two bytes over a req/ack byte bus and
// drives the external PC and IR function-select registers.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Flush,
  output logic              Busy,
  output logic              Done,
  input  logic [WORD_W-1:0] PcQ,
  output logic              PcE,
  output logic [1:0]        PcFunSel,
  output logic              MemReq,
  output logic [WORD_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [BYTE_W-1:0] MemData,
  output logic [WORD_W-1:0] IrI,
  output logic              IrE,
  output logic [1:0]        IrFunSel
);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   addr;
  logic [WORD_W-1:0]   addr_p1;
  logic [BYTE_W-1:0]   byte0, byte1;
  logic [WORD_W-1:0]   word_asm;
  logic [WORD_W-1:0]   ir_hold;

  logic                ld_addr, cap0, cap1, ld_ir;
  logic                busy_c, done_c, req_c, pc_e_c, ir_e_c;
  logic [1:0]          pc_fs_c, ir_fs_c;
  logic [WORD_W-1:0]   addr_c;

  // Second byte address wraps naturally at 16 bits.
  assign addr_p1  = addr + 16'd1;
  assign word_asm = LOW_FIRST ? {byte1, byte0} : {byte0, byte1};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      addr    <= '0;
      byte0   <= '0;
      byte1   <= '0;
      ir_hold <= '0;
    end else begin
      state <= state_nxt;
      if (ld_addr) addr    <= PcQ;
      if (cap0)    byte0   <= MemData;
      if (cap1)    byte1   <= MemData;
      if (ld_ir)   ir_hold <= word_asm;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_addr   = 1'b0;
    cap0      = 1'b0;
    cap1      = 1'b0;
    ld_ir     = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    req_c     = 1'b0;
    addr_c    = '0;
    pc_e_c    = 1'b0;
    pc_fs_c   = FS_DEC;
    ir_e_c    = 1'b0;
    ir_fs_c   = FS_DEC;

    unique case (state)
      ST_IDLE: begin
        if (Start) begin
          ld_addr   = 1'b1;
          state_nxt = ST_REQ0;
        end
      end
      ST_REQ0: begin
        busy_c = 1'b1;
        req_c  = 1'b1;
        addr_c = addr;
        if (MemAck) begin
          cap0      = 1'b1;
          pc_e_c    = 1'b1;
          pc_fs_c   = FS_INC;
          state_nxt = ST_REQ1;
        end
      end
      ST_REQ1: begin
        busy_c = 1'b1;
        req_c  = 1'b1;
        addr_c = addr_p1;
        if (MemAck) begin
          cap1      = 1'b1;
          pc_e_c    = 1'b1;
          pc_fs_c   = FS_INC;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        ir_e_c    = 1'b1;
        ir_fs_c   = FS_LOAD;
        ld_ir     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Flush overrides Start, acks and the load; the bus request stays Moore.
    if (Flush) begin
      state_nxt = ST_IDLE;
      ld_addr   = 1'b0;
      cap0      = 1'b0;
      cap1      = 1'b0;
      ld_ir     = 1'b0;
      done_c    = 1'b0;
      pc_e_c    = 1'b0;
      pc_fs_c   = FS_DEC;
      ir_e_c    = 1'b1;
      ir_fs_c   = FS_CLR;
    end

    if (Reset) begin
      busy_c  = 1'b0;
      done_c  = 1'b0;
      req_c   = 1'b0;
      addr_c  = '0;
      pc_e_c  = 1'b0;
      pc_fs_c = FS_DEC;
      ir_e_c  = 1'b0;
      ir_fs_c = FS_DEC;
    end
  end

  assign Busy     = busy_c;
  assign Done     = done_c;
  assign MemReq   = req_c;
  assign MemAddr  = addr_c;
  assign PcE      = pc_e_c;
  assign PcFunSel = pc_fs_c;
  assign IrE      = ir_e_c;
  assign IrFunSel = ir_fs_c;
  // Outside LOAD the word holds the last value actually handed to the IR.
  assign IrI      = Reset ? '0 : ((state == ST_LOAD) ? word_asm : ir_hold);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level model checked every cycle,
// with external PC/IR function-select registers closing the loop.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Reset, Start, Flush;
  logic        Busy, Done, PcE, IrE, MemReq, MemAck;
  logic [1:0]  PcFunSel, IrFunSel;
  logic [15:0] MemAddr, IrI;
  logic [7:0]  MemData;
  logic        Busy1, Done1, PcE1, IrE1, MemReq1;
  logic [1:0]  PcFunSel1, IrFunSel1;
  logic [15:0] MemAddr1, IrI1;

  logic [15:0] pc_q, ir_q, ir1_q, pc_ld_val;
  logic        pc_load, ack_force;
  int          ack_delay, wcnt;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  bit done_flag = 0;

  bit         m_active = 0;
  int         m_n = 0;
  logic [15:0] m_base = '0;
  logic [7:0]  m_f = '0, m_s = '0;

  always #5 clk = ~clk;

  fetch_sequencer #(.LOW_FIRST(1'b1)) dut (
    .Clock(clk), .Reset(Reset), .Start(Start), .Flush(Flush), .Busy(Busy), .Done(Done),
    .PcQ(pc_q), .PcE(PcE), .PcFunSel(PcFunSel), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .IrI(IrI), .IrE(IrE), .IrFunSel(IrFunSel)
  );

  fetch_sequencer #(.LOW_FIRST(1'b0)) dut1 (
    .Clock(clk), .Reset(Reset), .Start(Start), .Flush(Flush), .Busy(Busy1), .Done(Done1),
    .PcQ(pc_q), .PcE(PcE1), .PcFunSel(PcFunSel1), .MemReq(MemReq1), .MemAddr(MemAddr1),
    .MemAck(MemAck), .MemData(MemData), .IrI(IrI1), .IrE(IrE1), .IrFunSel(IrFunSel1)
  );

  assign MemData = mem[MemAddr];
  assign MemAck  = ack_force | (MemReq && (wcnt >= ack_delay));

  always_ff @(posedge clk) begin
    if (Reset) wcnt <= 0;
    else if (MemReq && MemAck) wcnt <= 0;
    else if (MemReq) wcnt <= wcnt + 1;
  end

  // Team function-select registers: 00 dec, 01 inc, 10 load, 11 clear.
  always_ff @(posedge clk) begin
    if (Reset) pc_q <= '0;
    else if (pc_load) pc_q <= pc_ld_val;
    else if (PcE)
      case (PcFunSel)
        2'b00: pc_q <= pc_q - 16'd1;
        2'b01: pc_q <= pc_q + 16'd1;
        2'b10: pc_q <= '0;
        default: pc_q <= '0;
      endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ir_q  <= '0;
      ir1_q <= '0;
    end else begin
      if (IrE)
        case (IrFunSel)
          2'b00: ir_q <= ir_q - 16'd1;
          2'b01: ir_q <= ir_q + 16'd1;
          2'b10: ir_q <= IrI;
          default: ir_q <= '0;
        endcase
      if (IrE1)
        case (IrFunSel1)
          2'b00: ir1_q <= ir1_q - 16'd1;
          2'b01: ir1_q <= ir1_q + 16'd1;
          2'b10: ir1_q <= IrI1;
          default: ir1_q <= '0;
        endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic e_busy, e_done, e_req, e_pce, e_ire, e_load, acc, chk_w;
    logic [1:0]  e_pfs, e_ifs;
    logic [15:0] e_addr, e_w1, e_w0;
    e_busy = 0; e_done = 0; e_req = 0; e_pce = 0; e_ire = 0; chk_w = 0;
    e_pfs = 2'b00; e_ifs = 2'b00; e_addr = '0; e_w1 = '0; e_w0 = '0;
    if (Reset) begin
      chk_w = 1;
    end else begin
      e_busy = m_active;
      e_req  = m_active && (m_n < 2);
      e_addr = e_req ? m_base + 16'(m_n) : 16'h0000;
      e_load = m_active && (m_n == 2);
      if (Flush) begin
        e_ire = 1; e_ifs = 2'b11;
      end else begin
        acc   = e_req && MemAck;
        e_pce = acc;
        e_pfs = acc ? 2'b01 : 2'b00;
        e_ire = e_load;
        e_ifs = e_load ? 2'b10 : 2'b00;
        e_done = e_load;
        chk_w = e_load;
        e_w1 = {m_s, m_f};
        e_w0 = {m_f, m_s};
      end
    end
    chk("busy", 32'(Busy), 32'(e_busy));
    chk("done", 32'(Done), 32'(e_done));
    chk("memreq", 32'(MemReq), 32'(e_req));
    chk("memaddr", 32'(MemAddr), 32'(e_addr));
    chk("pce", 32'(PcE), 32'(e_pce));
    chk("pcfunsel", 32'(PcFunSel), 32'(e_pfs));
    chk("ire", 32'(IrE), 32'(e_ire));
    chk("irfunsel", 32'(IrFunSel), 32'(e_ifs));
    chk("b_done", 32'(Done1), 32'(e_done));
    chk("b_memaddr", 32'(MemAddr1), 32'(e_addr));
    chk("b_pce", 32'(PcE1), 32'(e_pce));
    chk("b_busy", 32'(Busy1), 32'(e_busy));
    chk("b_memreq", 32'(MemReq1), 32'(e_req));
    chk("b_pcfunsel", 32'(PcFunSel1), 32'(e_pfs));
    chk("b_irfunsel", 32'(IrFunSel1), 32'(e_ifs));
    if (chk_w) begin
      chk("iri_lowfirst", 32'(IrI), 32'(e_w1));
      chk("iri_highfirst", 32'(IrI1), 32'(e_w0));
    end
    done_flag = (Done === 1'b1);
    if (done_flag) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (Reset) begin
      m_active = 0; m_n = 0; m_f = '0; m_s = '0;
    end else if (Flush) begin
      m_active = 0;
    end else if (!m_active) begin
      if (Start) begin
        m_active = 1; m_base = pc_q; m_n = 0;
      end
    end else if (m_n < 2) begin
      if (MemAck) begin
        if (m_n == 0) m_f = mem[m_base];
        else          m_s = mem[m_base + 16'd1];
        m_n++;
      end
    end else begin
      m_active = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_load = 1; pc_ld_val = v;
    step();
    pc_load = 0;
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_flag) begin
        at = last_done_cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout cyc=%0d got=none want=Done within %0d", cyc, bound);
    end
  endtask

  task automatic fetch(input logic [15:0] pc, output int lat);
    int s, at;
    set_pc(pc);
    Start = 1; s = cyc;
    step();
    Start = 0;
    wait_done(40, at);
    lat = at - s;
  endtask

  initial begin
    int lat, d0, first_done;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
    mem[16'h0042] = 8'h11; mem[16'h0043] = 8'h22;
    mem[16'h0044] = 8'h33; mem[16'h0045] = 8'h44;
    mem[16'h0100] = 8'hEF; mem[16'h0101] = 8'hBE;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    Reset = 1; Start = 0; Flush = 0; pc_load = 0; pc_ld_val = '0;
    ack_force = 0; ack_delay = 0;
    step(); step();
    Reset = 0;
    step();

    // Basic fetch, ack tied high
    fetch(16'h0040, lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_ir", 32'(ir_q), 32'h1234);
    chk("t1_ir_highfirst", 32'(ir1_q), 32'h3412);
    chk("t1_pc", 32'(pc_q), 32'h0042);

    // Slow memory
    ack_delay = 3;
    fetch(16'h0100, lat);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_ir", 32'(ir_q), 32'hBEEF);
    chk("t2_pc", 32'(pc_q), 32'h0102);
    ack_delay = 0;

    // Address wrap
    fetch(16'hFFFF, lat);
    chk("t3_ir", 32'(ir_q), 32'hABCD);
    chk("t3_pc", 32'(pc_q), 32'h0001);

    // Flush in REQ1 together with an ack
    set_pc(16'h0200);
    d0 = done_count;
    Start = 1; step(); Start = 0;
    step();
    Flush = 1; step(); Flush = 0;
    step();
    chk("t4a_ir", 32'(ir_q), 32'h0000);
    chk("t4a_pc", 32'(pc_q), 32'h0201);
    chk("t4a_dones", 32'(done_count - d0), 32'd0);

    // Flush in LOAD
    fetch(16'h0040, lat);
    chk("t4b_pre_ir", 32'(ir_q), 32'h1234);
    set_pc(16'h0100);
    d0 = done_count;
    Start = 1; step(); Start = 0;
    step(); step();
    Flush = 1; step(); Flush = 0;
    step();
    chk("t4b_ir", 32'(ir_q), 32'h0000);
    chk("t4b_pc", 32'(pc_q), 32'h0102);
    chk("t4b_dones", 32'(done_count - d0), 32'd0);

    // Flush beats Start in IDLE
    Flush = 1; Start = 1; step(); Flush = 0; Start = 0;
    step(); step();
    chk("t4c_pc", 32'(pc_q), 32'h0102);
    chk("t4c_dones", 32'(done_count - d0), 32'd0);

    // Reset in REQ0
    set_pc(16'h0040);
    Start = 1; step(); Start = 0;
    Reset = 1; step(); Reset = 0;
    step();
    chk("t5_pc_after_reset", 32'(pc_q), 32'h0000);
    fetch(16'h0040, lat);
    chk("t5_latency", 32'(lat), 32'd3);
    chk("t5_ir", 32'(ir_q), 32'h1234);

    // Stray ack while idle is ignored
    ack_force = 1; step(); step(); ack_force = 0;
    chk("t6_stray_ack_pc", 32'(pc_q), 32'h0042);

    // Start held high: one acceptance every 4 cycles
    set_pc(16'h0040);
    d0 = done_count;
    first_done = -1;
    Start = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_flag && first_done < 0) first_done = last_done_cyc;
    end
    Start = 0;
    step(); step();
    chk("t6_dones", 32'(done_count - d0), 32'd3);
    chk("t6_spacing", 32'(last_done_cyc - first_done), 32'd8);
    chk("t6_pc", 32'(pc_q), 32'h0046);
    chk("t6_ir", 32'(ir_q), 32'h4433);
    chk("t6_ir_highfirst", 32'(ir1_q), 32'h3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
